// File: rtl/rf_wb_queue.sv
// rtl/rf_wb_queue.sv - in-order writeback queue merging ALU (A) and long-latency (B) producers into the RF write port
// Forwarding lookup is built only when RF_WBQ_FWD_EN is defined; otherwise fwd outputs are tied to zero.
module rf_wb_queue #(
    parameter int DEPTH   = 4,
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [RFIDX_W-1:0]         a_wa,
    input  logic [XLEN-1:0]            a_wd,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [RFIDX_W-1:0]         b_wa,
    input  logic [XLEN-1:0]            b_wd,
    output logic                       we3,
    output logic [RFIDX_W-1:0]         wa3,
    output logic [XLEN-1:0]            wd3,
    input  logic [RFIDX_W-1:0]         ra1,
    input  logic [RFIDX_W-1:0]         ra2,
    output logic                       fwd1_hit,
    output logic [XLEN-1:0]            fwd1_data,
    output logic                       fwd2_hit,
    output logic [XLEN-1:0]            fwd2_data,
    output logic [$clog2(DEPTH):0]     pending
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [RFIDX_W-1:0] r_wa [DEPTH];
    logic [XLEN-1:0]    r_wd [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_nonempty;
    logic [CNT_W-1:0]   w_free;
    logic               w_a_push;
    logic               w_b_push;
    logic [PTR_W-1:0]   w_b_ptr;

    assign w_nonempty = (r_count != '0);
    // The head always drains this cycle, so its slot counts as free for incoming pushes.
    assign w_free  = CNT_W'(DEPTH) - r_count + CNT_W'(w_nonempty);
    assign a_ready = (w_free >= CNT_W'(1));
    assign b_ready = (w_free >= CNT_W'(2)) | ((w_free >= CNT_W'(1)) & ~(a_valid & a_ready));

    // x0 writes complete the handshake but are never stored.
    assign w_a_push = a_valid & a_ready & (a_wa != '0);
    assign w_b_push = b_valid & b_ready & (b_wa != '0);
    assign w_b_ptr  = w_a_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_wa[i] <= '0;
                r_wd[i] <= '0;
            end
        end else begin
            if (w_nonempty) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_a_push) begin
                r_wa[r_wr_ptr] <= a_wa;
                r_wd[r_wr_ptr] <= a_wd;
            end
            if (w_b_push) begin
                r_wa[w_b_ptr] <= b_wa;
                r_wd[w_b_ptr] <= b_wd;
            end
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_a_push) + PTR_W'(w_b_push);
            r_count  <= r_count + CNT_W'(w_a_push) + CNT_W'(w_b_push) - CNT_W'(w_nonempty);
        end
    end

    assign we3     = w_nonempty;
    assign wa3     = w_nonempty ? r_wa[r_rd_ptr] : '0;
    assign wd3     = w_nonempty ? r_wd[r_rd_ptr] : '0;
    assign pending = r_count;

`ifdef RF_WBQ_FWD_EN
    // Walk from oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PTR_W-1:0] v_idx;
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        v_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_idx = r_rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < r_count) begin
                if ((ra1 != '0) && (r_wa[v_idx] == ra1)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = r_wd[v_idx];
                end
                if ((ra2 != '0) && (r_wa[v_idx] == ra2)) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = r_wd[v_idx];
                end
            end
        end
    end
`else
    logic w_unused_ra;
    assign w_unused_ra = ^{ra1, ra2};
    assign fwd1_hit    = 1'b0;
    assign fwd1_data   = '0;
    assign fwd2_hit    = 1'b0;
    assign fwd2_data   = '0;
`endif
endmodule

// File: tb/tb_rf_wb_queue.sv
// tb/tb_rf_wb_queue.sv - scoreboard bench for rf_wb_queue with a queue-based reference model
module tb_rf_wb_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int RW    = 5;
`ifdef RF_WBQ_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            a_valid, a_ready, b_valid, b_ready;
    logic [RW-1:0]   a_wa, b_wa, wa3, ra1, ra2;
    logic [XLEN-1:0] a_wd, b_wd, wd3, fwd1_data, fwd2_data;
    logic            we3, fwd1_hit, fwd2_hit;
    logic [2:0]      pending;

    rf_wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RFIDX_W(RW)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_wa(a_wa), .a_wd(a_wd),
        .b_valid(b_valid), .b_ready(b_ready), .b_wa(b_wa), .b_wd(b_wd),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0]   wa;
        logic [XLEN-1:0] wd;
    } ent_t;

    ent_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void fwd_model(input logic [RW-1:0] ra, output logic hit, output logic [XLEN-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (FWD_EN && ra != '0) begin
            foreach (exp_q[i]) begin
                if (exp_q[i].wa == ra) begin
                    hit = 1'b1;
                    d   = exp_q[i].wd;
                end
            end
        end
    endfunction

    int              m_sz, m_free;
    bit              m_ea, m_eb;
    logic            m_h1, m_h2;
    logic [XLEN-1:0] m_d1, m_d2;

    // Monitor: the register file commits the head on the negedge.
    always @(negedge clk) begin
        if (chk_en) begin
            m_sz   = exp_q.size();
            m_free = DEPTH - m_sz + ((m_sz != 0) ? 1 : 0);
            m_ea   = (m_free >= 1);
            m_eb   = (m_free >= 2) || ((m_free >= 1) && !(a_valid && m_ea));
            chk("pending", 64'(pending), 64'(m_sz));
            chk("a_ready", 64'(a_ready), 64'(m_ea));
            chk("b_ready", 64'(b_ready), 64'(m_eb));
            fwd_model(ra1, m_h1, m_d1);
            fwd_model(ra2, m_h2, m_d2);
            chk("fwd1_hit", 64'(fwd1_hit), 64'(m_h1));
            chk("fwd1_data", 64'(fwd1_data), 64'(m_d1));
            chk("fwd2_hit", 64'(fwd2_hit), 64'(m_h2));
            chk("fwd2_data", 64'(fwd2_data), 64'(m_d2));
            if (m_sz != 0) begin
                chk("we3", 64'(we3), 64'd1);
                chk("wa3", 64'(wa3), 64'(exp_q[0].wa));
                chk("wd3", 64'(wd3), 64'(exp_q[0].wd));
                void'(exp_q.pop_front());
            end else begin
                chk("we3_idle", 64'(we3), 64'd0);
                chk("wa3_idle", 64'(wa3), 64'd0);
                chk("wd3_idle", 64'(wd3), 64'd0);
            end
        end
    end

    task automatic cyc(input bit av, input logic [RW-1:0] awa, input logic [XLEN-1:0] awd,
                       input bit bv, input logic [RW-1:0] bwa, input logic [XLEN-1:0] bwd,
                       input logic [RW-1:0] r1, input logic [RW-1:0] r2);
        int  free;
        bit  a_acc, b_acc;
        a_valid = av; a_wa = awa; a_wd = awd;
        b_valid = bv; b_wa = bwa; b_wd = bwd;
        ra1 = r1; ra2 = r2;
        @(posedge clk);
        free  = DEPTH - exp_q.size();
        a_acc = av && (free >= 1);
        b_acc = bv && ((free >= 2) || ((free >= 1) && !a_acc));
        if (a_acc && awa != '0) exp_q.push_back('{awa, awd});
        if (b_acc && bwa != '0) exp_q.push_back('{bwa, bwd});
        #1;
    endtask

    task automatic idle(input int n, input logic [RW-1:0] r1, input logic [RW-1:0] r2);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    initial begin
        reset = 1'b1;
        a_valid = 0; a_wa = 0; a_wd = 0;
        b_valid = 0; b_wa = 0; b_wd = 0;
        ra1 = 0; ra2 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we3", 64'(we3), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_wa3", 64'(wa3), 64'd0);
        chk("rst_wd3", 64'(wd3), 64'd0);
        chk("rst_fwd1_hit", 64'(fwd1_hit), 64'd0);
        chk("rst_fwd2_data", 64'(fwd2_data), 64'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        cyc(1, 5, 32'h11, 0, 0, 0, 5, 0);
        idle(3, 5, 0);

        cyc(1, 3, 32'hA, 1, 3, 32'hB, 0, 0);
        idle(1, 3, 3);
        idle(3, 0, 0);

        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, RW'($urandom_range(1, 31)), $urandom, 0, 0);
        idle(2, 0, 0);

        for (int i = 0; i < 3; i++) cyc(1, RW'(i + 1), 32'h100 + i, 1, RW'(i + 9), 32'h200 + i, 2, 10);
        cyc(1, 7, 32'h777, 1, 8, 32'h888, 7, 1);
        idle(6, 0, 0);

        cyc(1, 0, 32'hFF, 0, 0, 0, 0, 0);
        idle(2, 0, 0);

        cyc(1, 4, 32'h44, 1, 6, 32'h66, 0, 0);
        cyc(1, 4, 32'h45, 1, 6, 32'h67, 4, 6);
        chk_en = 1'b0;
        reset  = 1'b1;
        #1;
        chk("midrst_we3", 64'(we3), 64'd0);
        chk("midrst_pending", 64'(pending), 64'd0);
        @(posedge clk);
        #1;
        chk("midrst_we3_hold", 64'(we3), 64'd0);
        exp_q.delete();
        reset  = 1'b0;
        chk_en = 1'b1;
        idle(3, 4, 6);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) < 6), RW'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 9) < 6), RW'($urandom_range(0, 7)), $urandom,
                RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)));
        end
        idle(8, 0, 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
